// File: rtl/chi_stage_pkg.sv
// -----------------------------------------------------------------------------
// chi_stage_pkg
//   Shared constants and FSM encoding for the Keccak chi stage.
//   - CHI_NUM_ROW / CHI_NUM_COLUMN / CHI_NUM_PAGE : state geometry (x, y, z)
//   - CHI_NUM_CELLS : total state bits (1600)
//   - CHI_J_W / CHI_K_W : y-counter and z-counter widths
//   - CHI_ADDR_W : width of the row base address 25*k + 5*j
//   - state_e : controller states IDLE / RUN / DONE
// -----------------------------------------------------------------------------
package chi_stage_pkg;

  localparam int CHI_NUM_ROW    = 5;
  localparam int CHI_NUM_COLUMN = 5;
  localparam int CHI_NUM_PAGE   = 64;
  localparam int CHI_NUM_CELLS  = CHI_NUM_ROW * CHI_NUM_COLUMN * CHI_NUM_PAGE;

  localparam int CHI_J_W    = 3;
  localparam int CHI_K_W    = 7;
  localparam int CHI_ADDR_W = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/chi_stage_counter.sv
// -----------------------------------------------------------------------------
// chi_counter
//   Modulo counter used for the row (j) and page (k) indices. Counters are
//   chained by feeding one counter's wrap_o into the next counter's en_i.
//   Ports:
//     clk, rst : clock and synchronous active-high reset
//     clr_i    : force count to zero (priority over en_i)
//     en_i     : advance by one; wraps MAX -> 0
//     cnt_o    : current count
//     wrap_o   : high in a cycle where the counter advances from MAX to 0
// -----------------------------------------------------------------------------
module chi_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_max;

  assign at_max = (cnt_q == W'(MAX));
  assign wrap_o = en_i & at_max;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chi_stage_row.sv
// -----------------------------------------------------------------------------
// chi_row
//   Combinational chi function on one 5-bit row:
//     out[x] = in[x] ^ (~in[(x+1) mod 5] & in[(x+2) mod 5])
//   Ports:
//     row_i : 5-bit row from the working register
//     row_o : 5-bit chi result
// -----------------------------------------------------------------------------
module chi_row
  import chi_stage_pkg::*;
(
  input  logic [CHI_NUM_ROW-1:0] row_i,
  output logic [CHI_NUM_ROW-1:0] row_o
);

  for (genvar x = 0; x < CHI_NUM_ROW; x++) begin : g_bit
    assign row_o[x] = row_i[x] ^
                      (~row_i[(x + 1) % CHI_NUM_ROW] & row_i[(x + 2) % CHI_NUM_ROW]);
  end

endmodule

// File: rtl/chi_stage.sv
// -----------------------------------------------------------------------------
// chi_stage
//   Keccak chi step on the 1600-bit state. On an accepted start the state is
//   copied into a working register, then one 5-bit row is rewritten in place
//   per cycle (j = y fastest, then k = z), 320 cycles in total. A one-cycle
//   done pulse follows, and data_out holds the result until the next start.
//   Ports:
//     clk      : clock, all state on the rising edge
//     rst      : synchronous active-high reset (wins over start)
//     start    : latch data_in and begin (accepted in IDLE and DONE only)
//     data_in  : state from pi, bit index 25*z + 5*y + x
//     busy     : high while rows are being processed
//     done     : single-cycle pulse, data_out complete
//     data_out : working register, same bit indexing as data_in
// -----------------------------------------------------------------------------
module chi_stage
  import chi_stage_pkg::*;
#(
  parameter int NUM_ROW    = CHI_NUM_ROW,
  parameter int NUM_COLUMN = CHI_NUM_COLUMN,
  parameter int NUM_PAGE   = CHI_NUM_PAGE
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [NUM_ROW*NUM_COLUMN*NUM_PAGE-1:0] data_in,
  output logic                                   busy,
  output logic                                   done,
  output logic [NUM_ROW*NUM_COLUMN*NUM_PAGE-1:0] data_out
);

  localparam int CELLS = NUM_ROW * NUM_COLUMN * NUM_PAGE;

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  state_e state_q;
  state_e state_d;

  logic load;      // accepted start: relatch data_in, clear counters
  logic run_en;    // a row is processed this cycle
  logic last_row;  // row (j=4, k=63) processed this cycle

  assign run_en = (state_q == ST_RUN);
  assign load   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)    state_d = ST_RUN;
      ST_RUN:  if (last_row) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  // ---------------------------------------------------------------------------
  // Datapath: chained row/page counters, row mux, chi, row demux
  // ---------------------------------------------------------------------------
  logic [CHI_J_W-1:0]    j_cnt;
  logic [CHI_K_W-1:0]    k_cnt;
  logic                  j_wrap;
  logic                  k_wrap;
  logic [CHI_ADDR_W-1:0] base;
  logic [NUM_ROW-1:0]    row_in;
  logic [NUM_ROW-1:0]    row_out;
  logic [CELLS-1:0]      work_q;
  logic [CELLS-1:0]      work_d;

  chi_counter #(
    .W   (CHI_J_W),
    .MAX (NUM_COLUMN - 1)
  ) u_j_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load),
    .en_i   (run_en),
    .cnt_o  (j_cnt),
    .wrap_o (j_wrap)
  );

  // k only advances when j wraps, so its own wrap marks the final row.
  chi_counter #(
    .W   (CHI_K_W),
    .MAX (NUM_PAGE - 1)
  ) u_k_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (load),
    .en_i   (j_wrap),
    .cnt_o  (k_cnt),
    .wrap_o (k_wrap)
  );

  assign last_row = k_wrap;

  // 25*k + 5*j peaks at 1595, so 11 bits hold it without truncation.
  assign base = CHI_ADDR_W'(k_cnt) * CHI_ADDR_W'(NUM_ROW * NUM_COLUMN)
              + CHI_ADDR_W'(j_cnt) * CHI_ADDR_W'(NUM_ROW);

  assign row_in = work_q[base +: NUM_ROW];

  chi_row u_chi_row (
    .row_i (row_in),
    .row_o (row_out)
  );

  // Rows are independent, so each result goes back into its own slot.
  always_comb begin
    work_d = work_q;
    if (load) begin
      work_d = data_in;
    end else if (run_en) begin
      work_d[base +: NUM_ROW] = row_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
    end else begin
      work_q <= work_d;
    end
  end

  assign data_out = work_q;

endmodule

// File: tb/tb_chi_stage.sv
module tb_chi_stage;

  localparam int N   = 1600;
  localparam int LAT = 320;  // edges from the start-sampling edge to DONE

  typedef struct {
    logic [N-1:0] d;
    int           t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] data_out;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   busy_run = 0;
  exp_t exp_q[$];

  chi_stage dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Reference chi over the whole state, straight from the bit-index rule.
  function automatic logic [N-1:0] chi_ref(input logic [N-1:0] a);
    logic [N-1:0] r;
    r = '0;
    for (int z = 0; z < 64; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          r[25*z + 5*y + x] = a[25*z + 5*y + x] ^
                              (~a[25*z + 5*y + (x+1)%5] & a[25*z + 5*y + (x+2)%5]);
    return r;
  endfunction

  function automatic logic [N-1:0] rand_state();
    logic [N-1:0] v;
    for (int i = 0; i < N/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_int(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    logic [N-1:0] diff;
    int first;
    n_vec++;
    diff = act ^ req;
    if (diff != '0) begin
      n_bad++;
      first = -1;
      for (int i = N-1; i >= 0; i--) if (diff[i]) first = i;
      $display("FAIL %s: %0d bits differ, first at bit %0d (got %b, required %b)",
               name, $countones(diff), first, act[first], req[first]);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) busy_run = 0;
    else if (busy) busy_run++;
    if (done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        e = exp_q.pop_front();
        chk_vec("data_out", data_out, e.d);
        chk_int("done_cycle", cyc, e.t);
        chk_int("busy_cycles", busy_run, LAT);
      end
      busy_run = 0;
    end
  end

  // Called #1 after a posedge; start is sampled at the next edge.
  task automatic issue(input logic [N-1:0] d, input logic [N-1:0] e, input bit push);
    exp_t x;
    start   = 1'b1;
    data_in = d;
    @(posedge clk); #1;
    start   = 1'b0;
    data_in = rand_state();  // must not affect the latched run
    if (push) begin
      x.d = e;
      x.t = cyc + LAT;
      exp_q.push_back(x);
    end
  endtask

  // Leaves the bench at the negedge of the DONE cycle.
  task automatic wait_done();
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, required one", n);
    end
  endtask

  task automatic to_idle();
    @(posedge clk); #1;
  endtask

  task automatic run_one(input logic [N-1:0] d, input logic [N-1:0] e);
    issue(d, e, 1'b1);
    wait_done();
    to_idle();
  endtask

  initial begin
    logic [N-1:0] d;
    logic [N-1:0] e;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_done", int'(done), 0);
    chk_vec("reset_data_out", data_out, '0);

    // start together with rst: reset wins
    start = 1'b1;
    data_in = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_int("start_with_rst_busy", int'(busy), 0);
    chk_vec("start_with_rst_data", data_out, '0);

    // Directed patterns, expectations written out by hand
    run_one('0, '0);
    run_one('1, '1);
    d = '0; d[1] = 1'b1;    e = '0; e[1] = 1'b1;    e[4] = 1'b1;
    run_one(d, e);
    d = '0; d[1595] = 1'b1; e = '0; e[1595] = 1'b1; e[1598] = 1'b1;
    run_one(d, e);
    d = '0; d[25] = 1'b1;   e = '0; e[25] = 1'b1;   e[28] = 1'b1;
    run_one(d, e);

    // start pulses during RUN are ignored
    d = rand_state();
    issue(d, chi_ref(d), 1'b1);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; data_in = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    repeat (189) @(posedge clk);
    #1;
    start = 1'b1; data_in = rand_state();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Back-to-back start in the DONE cycle
    d = rand_state();
    issue(d, chi_ref(d), 1'b1);
    wait_done();
    d = rand_state();
    issue(d, chi_ref(d), 1'b1);
    wait_done();
    to_idle();

    // Reset mid-RUN at run cycle 100
    d = rand_state();
    issue(d, '0, 1'b0);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_int("midrun_rst_busy", int'(busy), 0);
    chk_int("midrun_rst_done", int'(done), 0);
    chk_vec("midrun_rst_data_out", data_out, '0);
    rst = 1'b0;
    d = rand_state();
    run_one(d, chi_ref(d));

    // Random vectors, some issued back-to-back
    for (int i = 0; i < 50; i++) begin
      d = rand_state();
      issue(d, chi_ref(d), 1'b1);
      wait_done();
      if ($urandom_range(0, 1) == 0) to_idle();
    end
    to_idle();

    repeat (5) @(posedge clk);
    #1;
    chk_int("scoreboard_drained", exp_q.size(), 0);
    chk_int("final_idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/chi_stage.md
# chi_stage

Keccak chi step for the 1600-bit state, placed directly downstream of the permute (pi) stage. It latches the permuted state on `start` and walks the 320 five-bit rows, one row per cycle, using nested row/page counters. It then presents the chi result with a one-cycle `done` pulse, which the iota/round controller consumes.

## Interface
Parameters:
- `NUM_ROW`, 5, lanes per plane along x (row width)
- `NUM_COLUMN`, 5, planes along y
- `NUM_PAGE`, 64, slices along z (lane length)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset: synchronous, active-high
- `start`  in  1  request: latch `data_in` and begin
- `data_in`  in  1600  state from the pi stage; bit index = 25·z + 5·y + x
- `busy`  out  1  high while rows are being processed
- `done`  out  1  single-cycle pulse: `data_out` is complete
- `data_out`  out  1600  chi result, same bit indexing as `data_in`

## Operation
- Row (y,z) is the 5 bits at `[25·z + 5·y +: 5]`.
- Per row: out[x] = in[x] ^ (~in[(x+1) mod 5] & in[(x+2) mod 5]).
- FSM states:
  - IDLE: `busy`=0, `done`=0.
    - On `start`: copy `data_in` into the internal 1600-bit working register, clear the counters, go to RUN.
  - RUN: `busy`=1.
    - Each cycle: read the row addressed by y-counter j (0..4) and z-counter k (0..63) from the working register, compute chi, write 5 bits into the same positions of the working register.
    - Processing in place is safe because rows are independent.
    - j increments every cycle. On j wrap (4→0), k increments. When k=63 and j=4, the row is written and the FSM goes to DONE.
  - DONE: `done`=1 for exactly one cycle, `busy`=0.
    - Go to IDLE, or to RUN if `start` is high in this cycle (accepted exactly as in IDLE).
- `data_out` is driven directly from the working register.
  - Valid and stable from the DONE cycle until the next accepted `start`.
  - Intermediate values are visible while `busy`=1; consumers must not sample them.
- `start` while in RUN is ignored: no relatch, no counter effect.
- `data_in` is sampled only on an accepted `start`; it may change freely afterwards.
- Counter widths: j is 3 bits, k is 7 bits (overflow detection at 64). The row base address 25·k + 5·j is computed at 11 bits, with no truncation.

## Timing
- Reset (any state, including mid-RUN): on the next edge go to IDLE; working register = 0, j = k = 0, `busy`=0, `done`=0, `data_out`=0. The aborted computation is discarded.
- `start` sampled high in cycle 0 (IDLE):
  - `busy`=1 in cycles 1–320, one row per cycle in order (j fastest, then k).
  - `done`=1 in cycle 321.
  - IDLE from cycle 322.
- Latency from `start` to `done`: 321 cycles. Throughput: one state per 321 cycles with back-to-back `start` in the DONE cycle.
- `start` asserted together with `rst`: reset wins, and `start` is not accepted.

## Structure
- `ISA.v` holds `NUM_ROW`, `NUM_COLUMN`, `NUM_PAGE`, `NUM_CELLS` (1600) and the FSM state encodings (IDLE/RUN/DONE).
- Split into a controller (FSM) and a datapath (counters, working register, row mux/demux), matching the existing DP/controller split.
- Reuse the existing `Counter` module for j and k, chained by overflow.
- One combinational sub-module, `chi_row`: 5-bit in → 5-bit out chi function.

## Test plan
- **All-zero state:** `data_in`=0, `start` → `done` in cycle 321, `data_out`=0, `busy` high for exactly 320 cycles.
- **All-ones state:** `data_in` all ones → `data_out` all ones.
- **Single-bit rows:**
  - Bit 1 set only → `data_out` bits 1 and 4 set, all others 0.
  - Bit 1595 set only (last row) → bits 1595 and 1598 set.
  - Bit 25 set only (z=1, x=0) → bits 25 and 28 set.
- **Random vectors (≥50):** compare against a reference chi model. Change `data_in` right after `start` and check the result still matches the latched value.
- **Protocol:**
  - Pulse `start` at cycles 10 and 200 of RUN → ignored; a single `done` at cycle 321.
  - Assert `start` in the DONE cycle → next `done` exactly 321 cycles later, with the correct result.
- **Reset mid-RUN (cycle 100):** `busy`, `done`, `data_out` = 0 on the next cycle. A fresh `start` then yields the correct result with no residue from the aborted run.
